sd_cmd_arbiter: RTL

Shares the single SD command-issue path between two requesters: host software (register-driven commands) and the auto-command engine (AUTO_CMD12/CMD23). Grants one requester at a time and forwards its command fields to the command path. Issues a one-cycle emmit strobe, then waits for command_complete. A watchdog bounds the wait, and the block returns per-requester done/error status. Sits between the host register block / auto-command engine and the command control/serializer.

---
 rtl/sd_cmd_arbiter.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter
//
// Shares the single SD command-issue path between host software and the
// auto-command engine (AUTO_CMD12 / CMD23). One requester is granted at a
// time. The winner's command fields are latched and a one-cycle issue
// strobe is sent to the command path. The block then waits for
// command_complete, with a watchdog bounding the wait, and returns a
// done pulse plus error status to the owner.
//
// Ports
//   clock, reset           system clock, asynchronous active-low reset
//   sw_*                   software request and its command fields
//   auto_*                 auto-command request and its fields (no type)
//   cmd_ready              command path idle and able to accept
//   command_complete       one-cycle completion pulse from command path
//   error_in               {end_bit, timeout, crc, index} errors, valid
//                          with command_complete
//   emmit_command          one-cycle issue strobe
//   cmd_index/argument,
//   response_type,
//   command_type           latched fields of the granted command
//   command_inhibit        high from grant until done
//   sw_grant/auto_grant    one-cycle accept pulse to the winner
//   sw_done/auto_done      one-cycle completion pulse to the owner
//   err_status             {watchdog, error_in}, valid with *_done
// ---------------------------------------------------------------------------
module sd_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sw_req,
    input  logic [5:0]  sw_index,
    input  logic [31:0] sw_argument,
    input  logic [1:0]  sw_response_type,
    input  logic [1:0]  sw_command_type,
    input  logic        auto_req,
    input  logic [5:0]  auto_index,
    input  logic [31:0] auto_argument,
    input  logic [1:0]  auto_response_type,
    input  logic        cmd_ready,
    input  logic        command_complete,
    input  logic [3:0]  error_in,
    output logic        emmit_command,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    output logic [1:0]  response_type,
    output logic [1:0]  command_type,
    output logic        command_inhibit,
    output logic        sw_grant,
    output logic        auto_grant,
    output logic        sw_done,
    output logic        auto_done,
    output logic [4:0]  err_status
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0]       CT_ABORT     = 2'd3;
    localparam logic [1:0]       CT_NORMAL    = 2'd0;
    localparam logic             OWNER_SW     = 1'b0;
    localparam logic             OWNER_AUTO   = 1'b1;
    localparam logic [4:0]       ERR_WATCHDOG = 5'b10000;
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,         state_d;
    logic [CNT_W-1:0]  cnt_q,           cnt_d;
    // Records the most recent winner. Because it is updated on every grant
    // it also identifies the owner of the transaction in flight.
    logic              last_grant_q,    last_grant_d;
    logic              emmit_q,         emmit_d;
    logic [5:0]        cmd_index_q,     cmd_index_d;
    logic [31:0]       cmd_argument_q,  cmd_argument_d;
    logic [1:0]        response_type_q, response_type_d;
    logic [1:0]        command_type_q,  command_type_d;
    logic              inhibit_q,       inhibit_d;
    logic              sw_grant_q,      sw_grant_d;
    logic              auto_grant_q,    auto_grant_d;
    logic              sw_done_q,       sw_done_d;
    logic              auto_done_q,     auto_done_d;
    logic [4:0]        err_status_q,    err_status_d;

    logic              pick_sw_s;
    logic              pick_auto_s;

    // Arbitration: an abort from software pre-empts everything, a lone
    // request wins outright, a tie goes to whoever did not win last time.
    always_comb begin
        pick_sw_s   = 1'b0;
        pick_auto_s = 1'b0;
        if (sw_req && (sw_command_type == CT_ABORT)) begin
            pick_sw_s = 1'b1;
        end else if (sw_req && auto_req) begin
            if (last_grant_q == OWNER_AUTO) begin
                pick_sw_s = 1'b1;
            end else begin
                pick_auto_s = 1'b1;
            end
        end else if (sw_req) begin
            pick_sw_s = 1'b1;
        end else if (auto_req) begin
            pick_auto_s = 1'b1;
        end else begin
            pick_sw_s   = 1'b0;
            pick_auto_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the IDLE/ISSUE/WAIT sequencer.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_grant_d    = last_grant_q;
        emmit_d         = 1'b0;
        cmd_index_d     = cmd_index_q;
        cmd_argument_d  = cmd_argument_q;
        response_type_d = response_type_q;
        command_type_d  = command_type_q;
        inhibit_d       = inhibit_q;
        sw_grant_d      = 1'b0;
        auto_grant_d    = 1'b0;
        sw_done_d       = 1'b0;
        auto_done_d     = 1'b0;
        err_status_d    = err_status_q;

        case (state_q)
            ST_IDLE: begin
                // Fields are captured only here; later changes on the
                // request side do not disturb the command in flight.
                if (cmd_ready && (pick_sw_s || pick_auto_s)) begin
                    state_d   = ST_ISSUE;
                    emmit_d   = 1'b1;
                    inhibit_d = 1'b1;
                    if (pick_sw_s) begin
                        sw_grant_d      = 1'b1;
                        last_grant_d    = OWNER_SW;
                        cmd_index_d     = sw_index;
                        cmd_argument_d  = sw_argument;
                        response_type_d = sw_response_type;
                        command_type_d  = sw_command_type;
                    end else begin
                        auto_grant_d    = 1'b1;
                        last_grant_d    = OWNER_AUTO;
                        cmd_index_d     = auto_index;
                        cmd_argument_d  = auto_argument;
                        response_type_d = auto_response_type;
                        command_type_d  = CT_NORMAL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // A completion arriving during the strobe cycle is ignored.
                state_d = ST_WAIT;
                cnt_d   = CNT_ZERO;
            end

            ST_WAIT: begin
                // A completion on the terminal-count cycle takes precedence
                // over the watchdog, so the watchdog bit stays clear.
                if (command_complete || (cnt_q == CNT_LAST)) begin
                    state_d   = ST_IDLE;
                    inhibit_d = 1'b0;
                    cnt_d     = CNT_ZERO;
                    if (last_grant_q == OWNER_AUTO) begin
                        auto_done_d = 1'b1;
                    end else begin
                        sw_done_d = 1'b1;
                    end
                    if (command_complete) begin
                        err_status_d = {1'b0, error_in};
                    end else begin
                        err_status_d = ERR_WATCHDOG;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                inhibit_d = 1'b0;
                cnt_d     = CNT_ZERO;
            end
        endcase
    end

    // State and output registers. Reset drops any transaction in flight
    // without a done pulse; software wins the first tie after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= CNT_ZERO;
            last_grant_q    <= OWNER_AUTO;
            emmit_q         <= 1'b0;
            cmd_index_q     <= 6'd0;
            cmd_argument_q  <= 32'd0;
            response_type_q <= 2'd0;
            command_type_q  <= 2'd0;
            inhibit_q       <= 1'b0;
            sw_grant_q      <= 1'b0;
            auto_grant_q    <= 1'b0;
            sw_done_q       <= 1'b0;
            auto_done_q     <= 1'b0;
            err_status_q    <= 5'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            last_grant_q    <= last_grant_d;
            emmit_q         <= emmit_d;
            cmd_index_q     <= cmd_index_d;
            cmd_argument_q  <= cmd_argument_d;
            response_type_q <= response_type_d;
            command_type_q  <= command_type_d;
            inhibit_q       <= inhibit_d;
            sw_grant_q      <= sw_grant_d;
            auto_grant_q    <= auto_grant_d;
            sw_done_q       <= sw_done_d;
            auto_done_q     <= auto_done_d;
            err_status_q    <= err_status_d;
        end
    end

    assign emmit_command   = emmit_q;
    assign cmd_index       = cmd_index_q;
    assign cmd_argument    = cmd_argument_q;
    assign response_type   = response_type_q;
    assign command_type    = command_type_q;
    assign command_inhibit = inhibit_q;
    assign sw_grant        = sw_grant_q;
    assign auto_grant      = auto_grant_q;
    assign sw_done         = sw_done_q;
    assign auto_done       = auto_done_q;
    assign err_status      = err_status_q;

endmodule
